// File: rtl/mmio_dbg_bridge_pkg.sv
// Shared opcodes, default response codes and FSM state encoding for the MMIO debug bridge.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mmio_dbg_bridge_pkg;

  localparam int ADDR_W = 15;

  localparam logic [7:0] OP_WR    = 8'h57;  // 'W' addrH addrL data
  localparam logic [7:0] OP_RD    = 8'h52;  // 'R' addrH addrL
  localparam logic [7:0] OP_BURST = 8'h42;  // 'B' addrH addrL count

  localparam logic [7:0] DEF_ACK_BYTE = 8'h2E;
  localparam logic [7:0] DEF_ERR_BYTE = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_AH,
    S_GET_AL,
    S_GET_ARG,
    S_WR,
    S_RD,
    S_RD_WAIT,
    S_RESP
  } state_t;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_WR) || (op == OP_RD) || (op == OP_BURST);
  endfunction

endpackage

// File: rtl/mmio_dbg_bridge_if.sv
// Command/response byte streams plus the MMIO initiator bus, grouped for the bridge.
// Latency: none (wiring only).
// Backpressure: rx_ready/tx_ready valid-ready handshakes carried through unchanged.
interface mmio_dbg_bridge_if;
  import mmio_dbg_bridge_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              bus_re;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic [7:0]        bus_rdata;

  // Bridge side
  modport master (
    input  rx_data, rx_valid,
    output rx_ready,
    output tx_data, tx_valid,
    input  tx_ready,
    output bus_re, bus_we, bus_addr, bus_wdata,
    input  bus_rdata
  );

  // Host byte link and MMIO peripheral side
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready,
    input  tx_data, tx_valid,
    output tx_ready,
    input  bus_re, bus_we, bus_addr, bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/mmio_dbg_bridge_rsp.sv
// Single-entry response holding register feeding the tx byte stream.
// Latency: byte loaded at edge N is presented with tx_valid from cycle N+1.
// Backpressure: data/valid held unchanged until i_rdy; loader must wait for it to empty.
module mmio_dbg_bridge_rsp (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_dat,
  input  logic       i_rdy,
  output logic       o_vld,
  output logic [7:0] o_dat
);

  logic       r_vld;
  logic [7:0] r_dat;

  // Capture a response byte on load; drop valid once the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= 8'h00;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (r_vld && i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/mmio_dbg_bridge.sv
// Byte-stream command parser driving single-cycle MMIO read/write strobes, with byte responses.
// Latency: strobe 1 cycle after last arg byte; write ack +2, read data +2+RD_LATENCY.
// Backpressure: rx_ready only while parsing; the FSM parks in RESP until the tx byte is taken.
module mmio_dbg_bridge
  import mmio_dbg_bridge_pkg::*;
#(
  parameter int         RD_LATENCY = 1,             // 1..4
  parameter logic [7:0] ACK_BYTE   = DEF_ACK_BYTE,
  parameter logic [7:0] ERR_BYTE   = DEF_ERR_BYTE
) (
  input  logic               clk,
  input  logic               rst_n,
  mmio_dbg_bridge_if.master  mif,
  output logic               busy
);

  localparam logic [1:0] LP_WAIT_LAST = 2'(RD_LATENCY - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_live;      // keeps rx_ready low while held in reset
  logic [7:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [8:0]        r_cnt;       // reads remaining in a burst, 1..256
  logic [1:0]        r_wait;

  logic              w_rx_fire;
  logic              w_tx_fire;
  logic              w_burst_more;
  logic              w_rsp_load;
  logic [7:0]        w_rsp_dat;
  logic              w_tx_vld;
  logic [7:0]        w_tx_dat;

  assign w_rx_fire    = mif.rx_valid && mif.rx_ready;
  assign w_tx_fire    = w_tx_vld && mif.tx_ready;
  assign w_burst_more = (r_op == OP_BURST) && (r_cnt > 9'd1);

  assign mif.rx_ready  = r_live && (r_state inside {S_IDLE, S_GET_AH, S_GET_AL, S_GET_ARG});
  assign mif.bus_re    = (r_state == S_RD);
  assign mif.bus_we    = (r_state == S_WR);
  assign mif.bus_addr  = r_addr;
  assign mif.bus_wdata = r_wdata;
  assign mif.tx_data   = w_tx_dat;
  assign mif.tx_valid  = w_tx_vld;
  assign busy          = (r_state != S_IDLE);

  mmio_dbg_bridge_rsp u_rsp (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_rsp_load),
    .i_dat  (w_rsp_dat),
    .i_rdy  (mif.tx_ready),
    .o_vld  (w_tx_vld),
    .o_dat  (w_tx_dat)
  );

  // State register; reset discards any partially received command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  // Next-state decode and response-register load
  always_comb begin
    w_state_nxt = r_state;
    w_rsp_load  = 1'b0;
    w_rsp_dat   = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          if (is_known_op(mif.rx_data)) begin
            w_state_nxt = S_GET_AH;
          end else begin
            w_rsp_load  = 1'b1;
            w_rsp_dat   = ERR_BYTE;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_GET_AH:  if (w_rx_fire) w_state_nxt = S_GET_AL;
      S_GET_AL:  if (w_rx_fire) w_state_nxt = (r_op == OP_RD) ? S_RD : S_GET_ARG;
      S_GET_ARG: if (w_rx_fire) w_state_nxt = (r_op == OP_WR) ? S_WR : S_RD;
      S_WR: begin
        w_rsp_load  = 1'b1;
        w_rsp_dat   = ACK_BYTE;
        w_state_nxt = S_RESP;
      end
      S_RD:      w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (r_wait == LP_WAIT_LAST) begin
          w_rsp_load  = 1'b1;
          w_rsp_dat   = mif.bus_rdata;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:    if (w_tx_fire) w_state_nxt = w_burst_more ? S_RD : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Command fields, burst bookkeeping and read-wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 8'h00;
      r_addr  <= '0;
      r_wdata <= 8'h00;
      r_cnt   <= 9'd0;
      r_wait  <= 2'd0;
    end else begin
      r_wait <= (r_state == S_RD_WAIT) ? r_wait + 2'd1 : 2'd0;
      case (r_state)
        S_IDLE:   if (w_rx_fire) r_op <= mif.rx_data;
        S_GET_AH: if (w_rx_fire) r_addr[ADDR_W-1:8] <= mif.rx_data[6:0];
        S_GET_AL: if (w_rx_fire) r_addr[7:0] <= mif.rx_data;
        S_GET_ARG: begin
          if (w_rx_fire) begin
            if (r_op == OP_WR) r_wdata <= mif.rx_data;
            else               r_cnt   <= {(mif.rx_data == 8'h00), mif.rx_data};
          end
        end
        S_RESP: begin
          if (w_tx_fire && w_burst_more) begin
            r_cnt  <= r_cnt - 9'd1;
            r_addr <= r_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_dbg_bridge.sv
// Directed bench for mmio_dbg_bridge: scoreboards for tx bytes, read and write strobes.
// Latency: checks strobe, ack, read-data timing and burst spacing.
// Backpressure: random tx_ready during a 256-read burst, checking hold stability.
module tb_mmio_dbg_bridge;
  import mmio_dbg_bridge_pkg::*;

  localparam int RDL = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  mmio_dbg_bridge_if mif();

  mmio_dbg_bridge #(
    .RD_LATENCY (RDL),
    .ACK_BYTE   (8'h2E),
    .ERR_BYTE   (8'h3F)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mif   (mif),
    .busy  (busy)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_tx_q[$];
  logic [14:0] exp_re_q[$];
  logic [22:0] exp_we_q[$];

  int   re_cnt = 0;
  int   we_cnt = 0;
  int   cyc = 0;
  int   last_re = -1;
  bit   chk_space = 1'b0;
  bit   bp_en = 1'b0;
  bit   tx_stall = 1'b0;
  logic [7:0] tx_held = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral read data: 0310 holds 3C, everything else returns its low address byte
  function automatic logic [7:0] mem_f(input logic [14:0] a);
    return (a == 15'h0310) ? 8'h3C : a[7:0];
  endfunction

  // MMIO model: read data appears one clock after bus_re
  always @(posedge clk) begin
    if (mif.bus_re) mif.bus_rdata <= mem_f(mif.bus_addr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Random downstream readiness, changed just after the edge
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      mif.tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Bus and response monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mif.bus_re || mif.bus_we)
      check("re_we_excl", {31'd0, mif.bus_re & mif.bus_we}, 32'd0);
    if (mif.bus_re) begin
      re_cnt++;
      check("re_expected", {31'd0, exp_re_q.size() != 0}, 32'd1);
      if (exp_re_q.size() != 0) check("re_addr", {17'd0, mif.bus_addr}, {17'd0, exp_re_q.pop_front()});
      if (chk_space && last_re >= 0) check("re_space", cyc - last_re, RDL + 2);
      last_re = cyc;
    end
    if (mif.bus_we) begin
      we_cnt++;
      check("we_expected", {31'd0, exp_we_q.size() != 0}, 32'd1);
      if (exp_we_q.size() != 0) check("we_addr_dat", {9'd0, mif.bus_addr, mif.bus_wdata}, {9'd0, exp_we_q.pop_front()});
    end
    if (tx_stall && rst_n) begin
      check("tx_hold_vld", {31'd0, mif.tx_valid}, 32'd1);
      check("tx_hold_dat", {24'd0, mif.tx_data}, {24'd0, tx_held});
    end
    if (mif.tx_valid) check("rx_rdy_vs_tx", {31'd0, mif.rx_ready}, 32'd0);
    if (mif.tx_valid && mif.tx_ready) begin
      check("tx_expected", {31'd0, exp_tx_q.size() != 0}, 32'd1);
      if (exp_tx_q.size() != 0) check("tx_data", {24'd0, mif.tx_data}, {24'd0, exp_tx_q.pop_front()});
    end
    tx_stall = mif.tx_valid && !mif.tx_ready && rst_n;
    tx_held  = mif.tx_data;
  end

  // Caller sits on a falling edge; returns on the falling edge after the transfer
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    mif.rx_data  = b;
    mif.rx_valid = 1'b1;
    while (!mif.rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rx_accept_to", n, (n < 200) ? n : 0);
    @(negedge clk);
    mif.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_tx_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, n >= 5000}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_ready"},  {31'd0, mif.rx_ready}, 32'd0);
    check({tag, "_tx_valid"},  {31'd0, mif.tx_valid}, 32'd0);
    check({tag, "_tx_data"},   {24'd0, mif.tx_data}, 32'd0);
    check({tag, "_bus_re"},    {31'd0, mif.bus_re}, 32'd0);
    check({tag, "_bus_we"},    {31'd0, mif.bus_we}, 32'd0);
    check({tag, "_bus_addr"},  {17'd0, mif.bus_addr}, 32'd0);
    check({tag, "_bus_wdata"}, {24'd0, mif.bus_wdata}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

  initial begin
    mif.rx_valid = 1'b0;
    mif.rx_data  = 8'h00;
    mif.tx_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, addrH bit 7 ignored
    exp_we_q.push_back({15'h0005, 8'hA5});
    exp_tx_q.push_back(8'h2E);
    send_byte(8'h57); send_byte(8'h80); send_byte(8'h05); send_byte(8'hA5);
    check("wr_strobe", {31'd0, mif.bus_we}, 32'd1);
    check("wr_tx_early", {31'd0, mif.tx_valid}, 32'd0);
    @(negedge clk);
    check("wr_tx_lat", {31'd0, mif.tx_valid}, 32'd1);
    wait_idle("wr_idle_to");
    check("wr_we_cnt", we_cnt, 1);
    check("wr_re_cnt", re_cnt, 0);

    // Single read; data 3 cycles after addrL accepted
    exp_re_q.push_back(15'h0310);
    exp_tx_q.push_back(8'h3C);
    send_byte(8'h52); send_byte(8'h03); send_byte(8'h10);
    check("rd_strobe", {31'd0, mif.bus_re}, 32'd1);
    @(negedge clk);
    check("rd_tx_early", {31'd0, mif.tx_valid}, 32'd0);
    @(negedge clk);
    check("rd_tx_lat", {31'd0, mif.tx_valid}, 32'd1);
    wait_idle("rd_idle_to");
    check("rd_re_cnt", re_cnt, 1);
    check("rd_we_cnt", we_cnt, 1);

    // Burst across the 15-bit address wrap
    exp_re_q.push_back(15'h7FFE); exp_re_q.push_back(15'h7FFF); exp_re_q.push_back(15'h0000);
    exp_tx_q.push_back(8'hFE);    exp_tx_q.push_back(8'hFF);    exp_tx_q.push_back(8'h00);
    chk_space = 1'b1;
    last_re = -1;
    send_byte(8'h42); send_byte(8'h7F); send_byte(8'hFE); send_byte(8'h03);
    wait_idle("wrap_idle_to");
    chk_space = 1'b0;
    check("wrap_re_cnt", re_cnt, 4);
    check("wrap_busy", {31'd0, busy}, 32'd0);
    check("wrap_rx_ready", {31'd0, mif.rx_ready}, 32'd1);

    // 256-read burst under random backpressure
    for (int i = 0; i < 256; i++) begin
      exp_re_q.push_back(15'h0100 + 15'(i));
      exp_tx_q.push_back(mem_f(15'h0100 + 15'(i)));
    end
    bp_en = 1'b1;
    send_byte(8'h42); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    wait_idle("bp_idle_to");
    bp_en = 1'b0;
    mif.tx_ready = 1'b1;
    check("bp_re_cnt", re_cnt, 260);
    check("bp_re_left", exp_re_q.size(), 0);

    // Unknown opcode, then the following byte starts a new command
    exp_tx_q.push_back(8'h3F);
    send_byte(8'h11);
    wait_idle("bad_idle_to");
    check("bad_re_cnt", re_cnt, 260);
    check("bad_we_cnt", we_cnt, 1);
    exp_we_q.push_back({15'h0020, 8'h5A});
    exp_tx_q.push_back(8'h2E);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h20); send_byte(8'h5A);
    wait_idle("bad_next_to");
    check("bad_next_we_cnt", we_cnt, 2);

    // Reset in the middle of a write command
    send_byte(8'h57); send_byte(8'h12);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_re_q.push_back(15'h0001);
    exp_tx_q.push_back(8'h01);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    wait_idle("mid_rd_to");
    check("mid_we_cnt", we_cnt, 2);
    check("mid_re_cnt", re_cnt, 261);

    // Reset during the write strobe cycle: strobe drops at once, no ack follows
    exp_we_q.push_back({15'h0040, 8'h77});
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h40); send_byte(8'h77);
    check("strb_we_before", {31'd0, mif.bus_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("strb_we_after", {31'd0, mif.bus_we}, 32'd0);
    check("strb_tx_after", {31'd0, mif.tx_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("strb_no_ack", {31'd0, mif.tx_valid}, 32'd0);
    check("strb_busy", {31'd0, busy}, 32'd0);
    check("end_we_cnt", we_cnt, 3);
    check("end_tx_left", exp_tx_q.size(), 0);
    check("end_we_left", exp_we_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
